// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between a host and alu_cmd_sequencer.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready pairs.
// Ports: cmd_* (command in, valid/ready), rsp_* (result out, valid/ready).
// master = host side, slave = sequencer side.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 6,
    parameter int NREG  = 4
);
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [RW-1:0]    cmd_rd;
    logic [RW-1:0]    cmd_rs1;
    logic [RW-1:0]    cmd_rs2;
    logic [WIDTH-1:0] cmd_imm;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_zero;
    logic [RW-1:0]    rsp_rd;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_rd,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_rd,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences register-file ALU commands through an external combinational ALU.
// Latency: command accepted in cycle C -> rsp_valid in cycle C+2 (IDLE, EXEC, RESP).
// Backpressure: cmd_ready low in EXEC/RESP; response held stable until rsp_ready.
// Ports: clk/rst; bus (slave modport: cmd_*, rsp_*); alu_control/a/b out, alu_out/carry/zero in;
//        wr_en/wr_sel/wr_data host preload; rd_sel/rd_data combinational debug read.
// Optional feature: define SEQ_LOAD_IMM_EN to make op 4'b1111 a LOADI of cmd_imm that bypasses the ALU.
module alu_cmd_sequencer #(
    parameter int WIDTH = 6,
    parameter int NREG  = 4,
    localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_cmd_sequencer_if.slave    bus,
    output logic [3:0]            alu_control,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_carry,
    input  logic                  alu_zero,
    input  logic                  wr_en,
    input  logic [RW-1:0]         wr_sel,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [RW-1:0]         rd_sel,
    output logic [WIDTH-1:0]      rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic cmd_ready_c;
    logic rsp_valid_c;
    logic in_exec;
    logic accept;

    logic [WIDTH-1:0] regfile [NREG];
    logic [RW-1:0]    rd_q;

    logic [WIDTH-1:0] wb_data;
    logic             wb_carry;
    logic             wb_zero;

`ifdef SEQ_LOAD_IMM_EN
    localparam logic [3:0] OP_LOADI = 4'b1111;
    logic             is_loadi;
    logic             loadi_q;
    logic [WIDTH-1:0] imm_q;
    assign is_loadi = (bus.cmd_op == OP_LOADI);
`else
    // Immediate has no consumer without the LOADI feature.
    logic unused_imm;
    assign unused_imm = ^bus.cmd_imm;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        in_exec     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                in_exec = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept        = bus.cmd_valid & cmd_ready_c;
    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_c;

    // ---------------- Writeback source ----------------
    always_comb begin
        wb_data  = alu_out;
        wb_carry = alu_carry;
        wb_zero  = alu_zero;
`ifdef SEQ_LOAD_IMM_EN
        if (loadi_q) begin
            wb_data  = imm_q;
            wb_carry = 1'b0;
            wb_zero  = (imm_q == '0);
        end
`endif
    end

    // ---------------- Operand latch / ALU drive / response capture ----------------
    // The ALU input registers double as the operand latch: loaded at accept,
    // held through EXEC, cleared on the way out so the ALU sees 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_control   <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            rd_q          <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_rd    <= '0;
`ifdef SEQ_LOAD_IMM_EN
            loadi_q       <= 1'b0;
            imm_q         <= '0;
`endif
        end else begin
            if (accept) begin
                rd_q        <= bus.cmd_rd;
                alu_control <= bus.cmd_op;
                alu_a       <= regfile[bus.cmd_rs1];
                alu_b       <= regfile[bus.cmd_rs2];
`ifdef SEQ_LOAD_IMM_EN
                loadi_q     <= is_loadi;
                imm_q       <= bus.cmd_imm;
                if (is_loadi) begin
                    alu_control <= '0;
                    alu_a       <= '0;
                    alu_b       <= '0;
                end
`endif
            end
            if (in_exec) begin
                alu_control   <= '0;
                alu_a         <= '0;
                alu_b         <= '0;
                bus.rsp_data  <= wb_data;
                bus.rsp_carry <= wb_carry;
                bus.rsp_zero  <= wb_zero;
                bus.rsp_rd    <= rd_q;
            end
        end
    end

    // ---------------- Register file ----------------
    // Writeback is assigned after the host write so it wins on the same index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regfile[wr_sel] <= wr_data;
            end
            if (in_exec) begin
                regfile[rd_q] <= wb_data;
            end
        end
    end

    assign rd_data = regfile[rd_sel];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
    localparam int WIDTH = 6;
    localparam int NREG  = 4;
    localparam int RW    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(WIDTH), .NREG(NREG)) bus ();

    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic             alu_carry, alu_zero;
    logic             wr_en;
    logic [RW-1:0]    wr_sel, rd_sel;
    logic [WIDTH-1:0] wr_data, rd_data;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    // External combinational ALU; unknown codes return a ^ 6'h2A.
    logic [WIDTH:0] alu_t;
    always_comb begin
        alu_t     = '0;
        alu_carry = 1'b0;
        case (alu_control)
            4'b0000: alu_t[WIDTH-1:0] = alu_a & alu_b;
            4'b0001: alu_t[WIDTH-1:0] = alu_a | alu_b;
            4'b0010: begin alu_t = {1'b0, alu_a} + {1'b0, alu_b}; alu_carry = alu_t[WIDTH]; end
            4'b0011: begin alu_t = {1'b0, alu_a} - {1'b0, alu_b}; alu_carry = alu_t[WIDTH]; end
            4'b0100: alu_t[WIDTH-1:0] = alu_a << alu_b;
            4'b0101: alu_t[WIDTH-1:0] = alu_a >> alu_b;
            4'b0110: alu_t[WIDTH-1:0] = $signed(alu_a) >>> alu_b;
            4'b0111: alu_t[WIDTH-1:0] = ($signed(alu_a) < $signed(alu_b)) ? 6'd1 : 6'd0;
            4'b1001: alu_t[WIDTH-1:0] = alu_a ^ alu_b;
            default: alu_t[WIDTH-1:0] = alu_a ^ 6'h2A;
        endcase
        alu_out  = alu_t[WIDTH-1:0];
        alu_zero = (alu_out == '0);
    end

    typedef struct {
        logic [3:0]       op;
        logic [RW-1:0]    rd, rs1, rs2;
        logic [WIDTH-1:0] va, vb;
        logic [WIDTH-1:0] exp_data;
        logic             exp_carry, exp_zero;
    } vec_t;

    vec_t vecs [12];
    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                                input int va, input int vb, input int d, input int c, input int z);
        vec_t v;
        v.op = op; v.rd = RW'(rd); v.rs1 = RW'(rs1); v.rs2 = RW'(rs2);
        v.va = WIDTH'(va); v.vb = WIDTH'(vb); v.exp_data = WIDTH'(d);
        v.exp_carry = c[0]; v.exp_zero = z[0];
        return v;
    endfunction

    // All tasks are entered and left at a negedge.
    task automatic preload(input int sel, input int val);
        wr_en = 1'b1; wr_sel = RW'(sel); wr_data = WIDTH'(val);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input string tag, input logic [3:0] op, input int rd, input int rs1,
                            input int rs2, input int imm);
        chk({tag, " cmd_ready idle"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op;
        bus.cmd_rd = RW'(rd); bus.cmd_rs1 = RW'(rs1); bus.cmd_rs2 = RW'(rs2);
        bus.cmd_imm = WIDTH'(imm);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk({tag, " no rsp in exec"}, bus.rsp_valid, 0);
        chk({tag, " cmd_ready exec"}, bus.cmd_ready, 0);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " rsp latency extra cycles"}, n, 0);
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, " rsp_valid drop"}, bus.rsp_valid, 0);
    endtask

    task automatic peek(input string name, input int sel, input int exp);
        rd_sel = RW'(sel);
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        vecs[0]  = mk(4'b0010, 3, 1, 2, 5,    3,    8,    0, 0);
        vecs[1]  = mk(4'b0011, 0, 1, 2, 3,    5,    62,   1, 0);
        vecs[2]  = mk(4'b0011, 2, 1, 1, 7,    7,    0,    0, 1);
        vecs[3]  = mk(4'b0000, 2, 0, 1, 'h3C, 'h0F, 'h0C, 0, 0);
        vecs[4]  = mk(4'b0001, 1, 2, 3, 'h30, 'h03, 'h33, 0, 0);
        vecs[5]  = mk(4'b0010, 1, 0, 1, 63,   1,    0,    1, 1);
        vecs[6]  = mk(4'b0100, 2, 1, 3, 7,    2,    'h1C, 0, 0);
        vecs[7]  = mk(4'b0110, 3, 0, 2, 'h30, 2,    'h3C, 0, 0);
        vecs[8]  = mk(4'b0111, 0, 1, 2, 'h3F, 1,    1,    0, 0);
        vecs[9]  = mk(4'b1001, 1, 0, 3, 'h15, 'h3F, 'h2A, 0, 0);
        vecs[10] = mk(4'b0101, 2, 0, 1, 'h30, 4,    3,    0, 0);
        vecs[11] = mk(4'b0010, 1, 1, 2, 5,    3,    8,    0, 0);

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0;
        bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_imm = '0;
        bus.rsp_ready = 1'b0;
        wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_sel = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset cmd_ready", bus.cmd_ready, 1);
        chk("reset alu_control", alu_control, 0);
        @(negedge clk);

        // Table-driven ALU commands.
        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            preload(vecs[i].rs1, vecs[i].va);
            preload(vecs[i].rs2, vecs[i].vb);
            send_cmd(t, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, 0);
            chk({t, " alu_control"}, alu_control, vecs[i].op);
            chk({t, " alu_a"}, alu_a, vecs[i].va);
            chk({t, " alu_b"}, alu_b, vecs[i].vb);
            wait_rsp(t);
            chk({t, " rsp_data"},  bus.rsp_data,  vecs[i].exp_data);
            chk({t, " rsp_carry"}, bus.rsp_carry, vecs[i].exp_carry);
            chk({t, " rsp_zero"},  bus.rsp_zero,  vecs[i].exp_zero);
            chk({t, " rsp_rd"},    bus.rsp_rd,    vecs[i].rd);
            chk({t, " alu_control idle"}, alu_control, 0);
            finish_rsp(t);
            peek({t, " writeback"}, vecs[i].rd, vecs[i].exp_data);
            @(negedge clk);
        end

        // Reset asserted mid-EXEC.
        preload(1, 5);
        preload(2, 3);
        send_cmd("rstexec", 4'b0010, 3, 1, 2, 0);
        rst = 1'b1;
        #1;
        chk("rstexec rsp_valid", bus.rsp_valid, 0);
        chk("rstexec alu_control", alu_control, 0);
        chk("rstexec alu_a", alu_a, 0);
        chk("rstexec rsp_data", bus.rsp_data, 0);
        for (int r = 0; r < NREG; r++) peek($sformatf("rstexec rd_data%0d", r), r, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstexec cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);

        // Host write vs writeback, same register: writeback wins.
        preload(1, 5);
        preload(2, 3);
        send_cmd("coll", 4'b0010, 3, 1, 2, 0);
        wr_en = 1'b1; wr_sel = 2'd3; wr_data = 6'd9;
        @(negedge clk);
        wr_en = 1'b0;
        chk("coll rsp_valid", bus.rsp_valid, 1);
        chk("coll rsp_data", bus.rsp_data, 8);
        finish_rsp("coll");
        peek("coll r3", 3, 8);

        // Host write to an operand register during EXEC: both commit, op unaffected.
        send_cmd("diff", 4'b0010, 3, 1, 2, 0);
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 6'd20;
        @(negedge clk);
        wr_en = 1'b0;
        chk("diff rsp_data", bus.rsp_data, 8);
        finish_rsp("diff");
        peek("diff r1", 1, 20);
        peek("diff r3", 3, 8);
        preload(1, 5);

        // Response backpressure with a second command waiting.
        send_cmd("bp", 4'b0010, 3, 1, 2, 0);
        wait_rsp("bp");
        bus.cmd_valid = 1'b1; bus.cmd_op = 4'b0001;
        bus.cmd_rd = 2'd2; bus.cmd_rs1 = 2'd1; bus.cmd_rs2 = 2'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d rsp_valid", k), bus.rsp_valid, 1);
            chk($sformatf("bp hold%0d rsp_data", k), bus.rsp_data, 8);
            chk($sformatf("bp hold%0d rsp_rd", k), bus.rsp_rd, 3);
            chk($sformatf("bp hold%0d cmd_ready", k), bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp after hs rsp_valid", bus.rsp_valid, 0);
        chk("bp after hs cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("bp second alu_control", alu_control, 4'b0001);
        chk("bp second rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        chk("bp second rsp_valid late", bus.rsp_valid, 1);
        chk("bp second rsp_data", bus.rsp_data, 7);
        finish_rsp("bp2");

        // Opcode 1111: LOADI when enabled, otherwise forwarded to the ALU.
        preload(0, 'h2A);
        preload(2, 'h11);
        send_cmd("op15", 4'b1111, 2, 0, 0, 0);
`ifdef SEQ_LOAD_IMM_EN
        chk("op15 alu_control", alu_control, 0);
        chk("op15 alu_a", alu_a, 0);
`else
        chk("op15 alu_control", alu_control, 4'b1111);
        chk("op15 alu_a", alu_a, 'h2A);
`endif
        wait_rsp("op15");
        chk("op15 rsp_data", bus.rsp_data, 0);
        chk("op15 rsp_zero", bus.rsp_zero, 1);
        chk("op15 rsp_carry", bus.rsp_carry, 0);
        finish_rsp("op15");
        peek("op15 r2", 2, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
